pkt_checker: RTL and testbench

//  Passive, streaming byte-packet checker that produces packet_error for the

---
 rtl/pkt_checker.sv | 174 +++++++++++++++++
 tb/tb_pkt_checker.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_checker.sv
// pkt_checker
//   Passive streaming byte-packet checker. It watches one beat per cycle and
//   validates packet framing, header length and the 8-bit checksum. It emits a
//   one-cycle pulse for each violation or for each fully valid packet. It
//   applies no backpressure.
//
// Packet format: header beat (sop, data = payload length L), then L payload
// bytes, then a checksum beat (eop). A packet is legal when the 8-bit wrapping
// sum of the payload bytes plus the checksum byte is zero.
//
// Ports
//   clk          : clock, all logic on posedge
//   rstn         : synchronous active-low reset
//   in_valid     : beat qualifier; the other in_* inputs are ignored when low
//   in_sop       : first beat of a packet (header)
//   in_eop       : last beat of a packet (checksum)
//   in_data      : beat byte
//   packet_error : one-cycle pulse per detected violation
//   pkt_ok       : one-cycle pulse per fully valid packet
//   err_code     : code of the most recent error, held until the next error
//   ok_count     : saturating count of valid packets
//   err_count    : saturating count of error pulses
module pkt_checker #(
  parameter int MAX_LEN = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  input  logic             in_sop,
  input  logic             in_eop,
  input  logic [7:0]       in_data,
  output logic             packet_error,
  output logic             pkt_ok,
  output logic [2:0]       err_code,
  output logic [CNT_W-1:0] ok_count,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PAYLOAD,
    S_CKSUM,
    S_DROP
  } state_t;

  localparam logic [2:0] E_NONE  = 3'd0;
  localparam logic [2:0] E_NOSOP = 3'd1;
  localparam logic [2:0] E_LEN   = 3'd2;
  localparam logic [2:0] E_SOP   = 3'd3;
  localparam logic [2:0] E_EARLY = 3'd4;
  localparam logic [2:0] E_LATE  = 3'd5;
  localparam logic [2:0] E_CKSUM = 3'd6;

  localparam logic [7:0]       MAX_L8  = 8'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Counter increment that sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  state_t     state;
  logic [7:0] cnt;   // payload bytes still expected
  logic [7:0] sum;   // running 8-bit payload sum

  state_t     nstate;
  logic [7:0] ncnt;
  logic [7:0] nsum;
  logic       fire_err;
  logic       fire_ok;
  logic [2:0] ncode;

  logic       hdr_legal;
  logic [7:0] sum_add;

  // A header opens a packet only if it is not also the last beat and carries
  // a length in 1..MAX_LEN.
  assign hdr_legal = !in_eop && (in_data != 8'd0) && (in_data <= MAX_L8);
  assign sum_add   = sum + in_data;

  always_comb begin
    nstate   = state;
    ncnt     = cnt;
    nsum     = sum;
    fire_err = 1'b0;
    fire_ok  = 1'b0;
    ncode    = E_NONE;
    if (in_valid) begin
      if (in_sop) begin
        // Any sop is treated as a fresh header. Aborting an open packet
        // reports SOP and masks any header-length error on the same beat.
        if (state == S_PAYLOAD || state == S_CKSUM) begin
          fire_err = 1'b1;
          ncode    = E_SOP;
        end
        if (hdr_legal) begin
          nstate = S_PAYLOAD;
          ncnt   = in_data;
          nsum   = 8'd0;
        end else begin
          nstate = in_eop ? S_IDLE : S_DROP;
          if (!fire_err) begin
            fire_err = 1'b1;
            ncode    = E_LEN;
          end
        end
      end else begin
        unique case (state)
          S_IDLE: begin
            fire_err = 1'b1;
            ncode    = E_NOSOP;
          end
          S_PAYLOAD: begin
            if (in_eop) begin
              fire_err = 1'b1;
              ncode    = E_EARLY;
              nstate   = S_IDLE;
            end else begin
              nsum = sum_add;
              ncnt = cnt - 8'd1;
              if (cnt == 8'd1) nstate = S_CKSUM;
            end
          end
          S_CKSUM: begin
            if (in_eop) begin
              nstate = S_IDLE;
              if (sum_add == 8'd0) begin
                fire_ok = 1'b1;
              end else begin
                fire_err = 1'b1;
                ncode    = E_CKSUM;
              end
            end else begin
              fire_err = 1'b1;
              ncode    = E_LATE;
              nstate   = S_DROP;
            end
          end
          S_DROP: begin
            if (in_eop) nstate = S_IDLE;
          end
          default: nstate = S_IDLE;
        endcase
      end
    end
  end

  // Registered stage: state update and result pulses one cycle after the beat.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= S_IDLE;
      cnt          <= 8'd0;
      sum          <= 8'd0;
      packet_error <= 1'b0;
      pkt_ok       <= 1'b0;
      err_code     <= E_NONE;
      ok_count     <= '0;
      err_count    <= '0;
    end else begin
      state        <= nstate;
      cnt          <= ncnt;
      sum          <= nsum;
      packet_error <= fire_err;
      pkt_ok       <= fire_ok;
      if (fire_err) begin
        err_code  <= ncode;
        err_count <= sat_inc(err_count);
      end
      if (fire_ok) ok_count <= sat_inc(ok_count);
    end
  end

endmodule

// File: tb/tb_pkt_checker.sv
module tb_pkt_checker;
  localparam int MAX_LEN = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn;
  logic       in_valid;
  logic       in_sop;
  logic       in_eop;
  logic [7:0] in_data;

  logic        packet_error, pkt_ok;
  logic [2:0]  err_code;
  logic [15:0] ok_count, err_count;

  logic        s_packet_error, s_pkt_ok;
  logic [2:0]  s_err_code;
  logic [1:0]  s_ok_count, s_err_count;

  pkt_checker #(.MAX_LEN(MAX_LEN), .CNT_W(16)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_sop(in_sop),
    .in_eop(in_eop), .in_data(in_data), .packet_error(packet_error),
    .pkt_ok(pkt_ok), .err_code(err_code), .ok_count(ok_count),
    .err_count(err_count)
  );

  pkt_checker #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut_s (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_sop(in_sop),
    .in_eop(in_eop), .in_data(in_data), .packet_error(s_packet_error),
    .pkt_ok(s_pkt_ok), .err_code(s_err_code), .ok_count(s_ok_count),
    .err_count(s_err_count)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- reference model (packet-level view) ----------------
  // mode 0: between packets, 1: collecting a packet, 2: discarding to eop
  int              m_mode;
  int              m_len;
  byte unsigned    m_q[$];
  int              ok_n, err_n;
  logic [2:0]      m_code;
  bit              e_err, e_ok;

  function automatic int sat2(input int x);
    return (x > 3) ? 3 : x;
  endfunction

  function void model_reset();
    m_mode = 0; m_len = 0; m_q.delete();
    ok_n = 0; err_n = 0; m_code = 3'd0; e_err = 0; e_ok = 0;
  endfunction

  function void flag(input int c);
    e_err = 1; m_code = 3'(c); err_n++;
  endfunction

  function void model_hdr(input bit e, input logic [7:0] d, input bit report);
    if (!e && d >= 1 && d <= MAX_LEN) begin
      m_mode = 1; m_len = int'(d); m_q.delete();
    end else begin
      if (report) flag(2);
      m_mode = e ? 0 : 2;
    end
  endfunction

  function void model_beat(input bit s, input bit e, input logic [7:0] d);
    int total;
    e_err = 0; e_ok = 0;
    if (m_mode == 0) begin
      if (s) model_hdr(e, d, 1'b1);
      else flag(1);
    end else if (m_mode == 1) begin
      if (s) begin
        flag(3);
        model_hdr(e, d, 1'b0);
      end else if (m_q.size() < m_len) begin
        if (e) begin flag(4); m_mode = 0; end
        else m_q.push_back(d);
      end else if (e) begin
        total = int'(d);
        foreach (m_q[i]) total += int'(m_q[i]);
        if (total % 256 == 0) begin e_ok = 1; ok_n++; end
        else flag(6);
        m_mode = 0;
      end else begin
        flag(5); m_mode = 2;
      end
    end else begin
      if (s) model_hdr(e, d, 1'b1);
      else if (e) m_mode = 0;
    end
  endfunction

  // ---------------- stimulus primitives ----------------
  task automatic send(input bit v, input bit s, input bit e, input logic [7:0] d);
    in_valid = v; in_sop = s; in_eop = e; in_data = d;
    if (v) model_beat(s, e, d);
    else begin e_err = 0; e_ok = 0; end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  task automatic reset_dut();
    rstn = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = 8'h00;
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
  endtask

  task automatic send_good3();
    send(1, 1, 0, 8'h03);
    send(1, 0, 0, 8'h01);
    send(1, 0, 0, 8'h02);
    send(1, 0, 0, 8'h03);
    send(1, 0, 1, 8'hFA);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_dut();
    n_cmp++;
    if ({packet_error, pkt_ok, err_code, ok_count, err_count} !== 37'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got err=%0b ok=%0b code=%0d okc=%0d errc=%0d want all 0",
               packet_error, pkt_ok, err_code, ok_count, err_count);
    end
    n_cmp++;
    if ({s_packet_error, s_pkt_ok, s_err_code, s_ok_count, s_err_count} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_outputs_small: got %b want 0",
               {s_packet_error, s_pkt_ok, s_err_code, s_ok_count, s_err_count});
    end
  endtask

  task automatic test_good();
    int errs = 0;
    reset_dut();
    send(1, 1, 0, 8'h03); errs += packet_error;
    send(1, 0, 0, 8'h01); errs += packet_error;
    send(0, 1, 1, 8'h55); errs += packet_error;  // unqualified beat must be ignored
    send(1, 0, 0, 8'h02); errs += packet_error;
    send(1, 0, 0, 8'h03); errs += packet_error;
    n_cmp++;
    if (pkt_ok !== 1'b0) begin
      n_fail++; $display("FAIL good_no_early_ok: got pkt_ok=%0b want 0", pkt_ok);
    end
    send(1, 0, 1, 8'hFA); errs += packet_error;
    n_cmp++;
    if (pkt_ok !== 1'b1 || ok_count !== 16'd1) begin
      n_fail++; $display("FAIL good_pkt_ok: got pkt_ok=%0b ok_count=%0d want 1/1", pkt_ok, ok_count);
    end
    send(0, 0, 0, 8'h00);
    n_cmp++;
    if (errs != 0 || packet_error !== 1'b0 || pkt_ok !== 1'b0) begin
      n_fail++; $display("FAIL good_pulses: got errs=%0d pkt_ok=%0b want 0 errors and 1-cycle ok", errs, pkt_ok);
    end
  endtask

  task automatic test_bad_cksum();
    reset_dut();
    send(1, 1, 0, 8'h03);
    send(1, 0, 0, 8'h01);
    send(1, 0, 0, 8'h02);
    send(1, 0, 0, 8'h03);
    n_cmp++;
    if (packet_error !== 1'b0) begin
      n_fail++; $display("FAIL cksum_premature: got packet_error=%0b want 0", packet_error);
    end
    send(1, 0, 1, 8'hFB);
    n_cmp++;
    if (packet_error !== 1'b1 || err_code !== 3'd6 || err_count !== 16'd1 || pkt_ok !== 1'b0) begin
      n_fail++;
      $display("FAIL cksum_error: got err=%0b code=%0d errc=%0d ok=%0b want 1/6/1/0",
               packet_error, err_code, err_count, pkt_ok);
    end
  endtask

  task automatic test_framing();
    reset_dut();
    send(1, 0, 0, 8'h11);
    n_cmp++;
    if (packet_error !== 1'b1 || err_code !== 3'd1) begin
      n_fail++; $display("FAIL framing_nosop: got err=%0b code=%0d want 1/1", packet_error, err_code);
    end
    send(1, 1, 0, 8'h02);
    send(1, 0, 0, 8'hAA);
    send(1, 0, 1, 8'h00);
    n_cmp++;
    if (packet_error !== 1'b1 || err_code !== 3'd4) begin
      n_fail++; $display("FAIL framing_early: got err=%0b code=%0d want 1/4", packet_error, err_code);
    end
    send(1, 1, 0, 8'h01);
    send(1, 0, 0, 8'h05);
    send(1, 0, 0, 8'h00);
    n_cmp++;
    if (packet_error !== 1'b1 || err_code !== 3'd5) begin
      n_fail++; $display("FAIL framing_late: got err=%0b code=%0d want 1/5", packet_error, err_code);
    end
    send(1, 0, 0, 8'h33);
    send(1, 0, 1, 8'h44);
    n_cmp++;
    if (packet_error !== 1'b0 || err_count !== 16'd3) begin
      n_fail++; $display("FAIL framing_drop: got err=%0b errc=%0d want 0/3", packet_error, err_count);
    end
    send_good3();
    n_cmp++;
    if (pkt_ok !== 1'b1 || ok_count !== 16'd1) begin
      n_fail++; $display("FAIL framing_recover: got ok=%0b okc=%0d want 1/1", pkt_ok, ok_count);
    end
  endtask

  task automatic test_length();
    logic [7:0] b;
    int s = 0;
    reset_dut();
    send(1, 1, 0, 8'h00);
    n_cmp++;
    if (packet_error !== 1'b1 || err_code !== 3'd2) begin
      n_fail++; $display("FAIL len_zero: got err=%0b code=%0d want 1/2", packet_error, err_code);
    end
    send(1, 1, 0, 8'(MAX_LEN + 1));
    n_cmp++;
    if (packet_error !== 1'b1 || err_code !== 3'd2 || err_count !== 16'd2) begin
      n_fail++; $display("FAIL len_over: got err=%0b code=%0d errc=%0d want 1/2/2", packet_error, err_code, err_count);
    end
    send(1, 1, 0, 8'(MAX_LEN));
    for (int i = 0; i < MAX_LEN; i++) begin
      b = 8'($urandom_range(0, 255));
      s += int'(b);
      send(1, 0, 0, b);
    end
    send(1, 0, 1, 8'((256 - (s % 256)) % 256));
    n_cmp++;
    if (pkt_ok !== 1'b1 || packet_error !== 1'b0 || err_count !== 16'd2) begin
      n_fail++; $display("FAIL len_max: got ok=%0b err=%0b errc=%0d want 1/0/2", pkt_ok, packet_error, err_count);
    end
  endtask

  task automatic test_abort();
    int pulses = 0;
    reset_dut();
    send(1, 1, 0, 8'h04);
    send(1, 0, 0, 8'h10);
    send(1, 0, 0, 8'h20);
    send(1, 1, 0, 8'h01); pulses += packet_error;
    n_cmp++;
    if (packet_error !== 1'b1 || err_code !== 3'd3) begin
      n_fail++; $display("FAIL abort_sop: got err=%0b code=%0d want 1/3", packet_error, err_code);
    end
    send(1, 0, 0, 8'h7F); pulses += packet_error;
    send(1, 0, 1, 8'h81); pulses += packet_error;
    n_cmp++;
    if (pkt_ok !== 1'b1 || pulses != 1 || err_count !== 16'd1 || ok_count !== 16'd1) begin
      n_fail++;
      $display("FAIL abort_second: got ok=%0b pulses=%0d errc=%0d okc=%0d want 1/1/1/1",
               pkt_ok, pulses, err_count, ok_count);
    end
    // sop+eop while a packet is open: one SOP pulse, LEN masked, back to idle
    send(1, 1, 0, 8'h02);
    send(1, 1, 1, 8'h00);
    n_cmp++;
    if (packet_error !== 1'b1 || err_code !== 3'd3 || err_count !== 16'd2) begin
      n_fail++; $display("FAIL abort_sop_eop: got err=%0b code=%0d errc=%0d want 1/3/2", packet_error, err_code, err_count);
    end
    send(1, 0, 0, 8'h09);
    n_cmp++;
    if (err_code !== 3'd1) begin
      n_fail++; $display("FAIL abort_then_idle: got code=%0d want 1", err_code);
    end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    send(1, 1, 0, 8'h03);
    send(1, 0, 0, 8'h01);
    send(1, 0, 1, 8'hFF);  // early eop -> one error before the reset
    send(1, 1, 0, 8'h03);
    send(1, 0, 0, 8'h01);
    reset_dut();
    n_cmp++;
    if ({packet_error, pkt_ok, err_code, ok_count, err_count} !== 37'd0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got err=%0b ok=%0b code=%0d okc=%0d errc=%0d want all 0",
               packet_error, pkt_ok, err_code, ok_count, err_count);
    end
    send_good3();
    n_cmp++;
    if (pkt_ok !== 1'b1 || ok_count !== 16'd1 || err_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_mid_good: got ok=%0b okc=%0d errc=%0d want 1/1/0", pkt_ok, ok_count, err_count);
    end
    for (int i = 0; i < 5; i++) send(1, 0, 0, 8'(i));
    n_cmp++;
    if (s_err_count !== 2'd3 || err_count !== 16'd5 || s_ok_count !== 2'd1) begin
      n_fail++;
      $display("FAIL saturation: got small_errc=%0d errc=%0d small_okc=%0d want 3/5/1",
               s_err_count, err_count, s_ok_count);
    end
  endtask

  typedef struct { bit v; bit s; bit e; logic [7:0] d; } beat_t;
  beat_t bq[$];

  function void push(input bit s, input bit e, input logic [7:0] d);
    beat_t b;
    if ($urandom_range(0, 5) == 0) begin
      b.v = 0; b.s = 1'($urandom); b.e = 1'($urandom); b.d = 8'($urandom);
      bq.push_back(b);
    end
    b.v = 1; b.s = s; b.e = e; b.d = d;
    bq.push_back(b);
  endfunction

  task automatic test_random();
    int kind, len, cut, s;
    logic [7:0] b;
    logic [40:0] got, want;
    reset_dut();
    bq.delete();
    for (int p = 0; p < 70; p++) begin
      kind = $urandom_range(0, 10);
      len  = $urandom_range(1, MAX_LEN);
      if (kind == 10) begin
        push(1, 1'($urandom), ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)));
        if ($urandom_range(0, 1) == 1) push(0, 1, 8'($urandom));
      end else if (kind == 9) begin
        push(1'($urandom), 1'($urandom), 8'($urandom_range(0, 8)));
      end else begin
        cut = (kind == 6 || kind == 8) ? $urandom_range(0, len - 1) : len;
        s = 0;
        push(1, 0, 8'(len));
        for (int i = 0; i < cut; i++) begin
          b = 8'($urandom);
          s += int'(b);
          push(0, 0, b);
        end
        if (kind == 6) push(0, 1, 8'($urandom));
        else if (kind == 7) begin
          push(0, 0, 8'($urandom));
          push(0, 0, 8'($urandom));
          push(0, 1, 8'($urandom));
        end else if (kind <= 5) begin
          b = 8'((256 - (s % 256)) % 256);
          if (kind == 5) b = b + 8'($urandom_range(1, 255));
          push(0, 1, b);
        end
      end
    end
    foreach (bq[i]) begin
      send(bq[i].v, bq[i].s, bq[i].e, bq[i].d);
      got  = {packet_error, pkt_ok, err_code, ok_count, err_count, s_ok_count, s_err_count};
      want = {e_err, e_ok, m_code, 16'(ok_n), 16'(err_n), 2'(sat2(ok_n)), 2'(sat2(err_n))};
      n_cmp++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL random_beat%0d: got err=%0b ok=%0b code=%0d okc=%0d errc=%0d sokc=%0d serrc=%0d want err=%0b ok=%0b code=%0d okc=%0d errc=%0d",
                 i, packet_error, pkt_ok, err_code, ok_count, err_count, s_ok_count, s_err_count,
                 e_err, e_ok, m_code, ok_n, err_n);
      end
    end
  endtask

  initial begin
    rstn = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = 8'h00;
    model_reset();
    test_reset();
    test_good();
    test_bad_cksum();
    test_framing();
    test_length();
    test_abort();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
